// File: rtl/share_recombine_stage.sv
// share_recombine_stage: registered unmasking and byte-order stage.
// Converts a D-share bus to share-major layout, XOR-recombines the shares
// into one unmasked word and optionally reverses WIDTH-bit chunk order.
// A single valid/ready register stage holds shares and result together.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   in_valid       input word offered
//   in_ready       stage can accept (combinational from out_ready and rst)
//   in_bus         masked input word, COUNT*D bits
//   in_interleaved 1: in_bus bit-interleaved, 0: share-major
//   in_reverse     1: reverse chunk order of the recombined word
//   out_valid      output register holds a word
//   out_ready      consumer accepts the word
//   out_shares     registered share-major shares (never reversed)
//   out_data       registered unmasked, optionally reversed word

// Layout converter: bit i of share j moves from i*D+j to j*COUNT+i.
module share_layout_conv #(
  parameter int unsigned D     = 2,
  parameter int unsigned COUNT = 128
) (
  input  logic [COUNT*D-1:0] in_bus,
  input  logic               interleaved,
  output logic [COUNT*D-1:0] shares
);
  logic [COUNT*D-1:0] deint;

  for (genvar j = 0; j < D; j++) begin : g_share
    for (genvar i = 0; i < COUNT; i++) begin : g_bit
      assign deint[j*COUNT+i] = in_bus[i*D+j];
    end
  end

  assign shares = interleaved ? deint : in_bus;
endmodule

// XOR recombiner: folds D share-major shares into one COUNT-bit word.
module share_xor_recombine #(
  parameter int unsigned D     = 2,
  parameter int unsigned COUNT = 128
) (
  input  logic [COUNT*D-1:0] shares,
  output logic [COUNT-1:0]   rec
);
  logic [COUNT-1:0] acc [D+1];

  assign acc[0] = '0;
  for (genvar j = 0; j < D; j++) begin : g_fold
    assign acc[j+1] = acc[j] ^ shares[j*COUNT +: COUNT];
  end

  assign rec = acc[D];
endmodule

// Chunk reverser: swaps chunk k with chunk N-1-k, keeping in-chunk bit order.
module chunk_reverse #(
  parameter int unsigned COUNT = 128,
  parameter int unsigned WIDTH = 8
) (
  input  logic [COUNT-1:0] data,
  input  logic             reverse,
  output logic [COUNT-1:0] result
);
  localparam int unsigned N = COUNT / WIDTH;

  logic [COUNT-1:0] rev;

  for (genvar k = 0; k < N; k++) begin : g_chunk
    assign rev[k*WIDTH +: WIDTH] = data[(N-1-k)*WIDTH +: WIDTH];
  end

  assign result = reverse ? rev : data;
endmodule

module share_recombine_stage #(
  parameter int unsigned D     = 2,
  parameter int unsigned COUNT = 128,
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COUNT*D-1:0] in_bus,
  input  logic               in_interleaved,
  input  logic               in_reverse,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT*D-1:0] out_shares,
  output logic [COUNT-1:0]   out_data
);
  logic [COUNT*D-1:0] shares;
  logic [COUNT-1:0]   rec;
  logic [COUNT-1:0]   data_next;
  logic               accept;

  share_layout_conv #(.D(D), .COUNT(COUNT)) u_conv (
    .in_bus      (in_bus),
    .interleaved (in_interleaved),
    .shares      (shares)
  );

  share_xor_recombine #(.D(D), .COUNT(COUNT)) u_rec (
    .shares (shares),
    .rec    (rec)
  );

  chunk_reverse #(.COUNT(COUNT), .WIDTH(WIDTH)) u_rev (
    .data    (rec),
    .reverse (in_reverse),
    .result  (data_next)
  );

  // Ready whenever the register is empty or being drained; forced low in reset.
  assign in_ready = rst & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Output register: load on accept, clear valid on drain, data held otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_shares <= '0;
      out_data   <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_shares <= shares;
      out_data   <= data_next;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_share_recombine_stage.sv
// Directed self-checking bench: D=2 instance for mapping, reversal,
// masking, back-pressure and reset; D=3 instance for throughput.
module tb_share_recombine_stage;
  logic         clk;
  logic         rst;

  logic         in_valid;
  logic         in_ready;
  logic [255:0] in_bus;
  logic         in_interleaved;
  logic         in_reverse;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out_shares;
  logic [127:0] out_data;

  logic         b_in_valid;
  logic         b_in_ready;
  logic [383:0] b_in_bus;
  logic         b_in_interleaved;
  logic         b_in_reverse;
  logic         b_out_valid;
  logic         b_out_ready;
  logic [383:0] b_out_shares;
  logic [127:0] b_out_data;

  int vectors;
  int miscompares;

  share_recombine_stage #(.D(2), .COUNT(128), .WIDTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_bus         (in_bus),
    .in_interleaved (in_interleaved),
    .in_reverse     (in_reverse),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_shares     (out_shares),
    .out_data       (out_data)
  );

  share_recombine_stage #(.D(3), .COUNT(128), .WIDTH(8)) dut3 (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (b_in_valid),
    .in_ready       (b_in_ready),
    .in_bus         (b_in_bus),
    .in_interleaved (b_in_interleaved),
    .in_reverse     (b_in_reverse),
    .out_valid      (b_out_valid),
    .out_ready      (b_out_ready),
    .out_shares     (b_out_shares),
    .out_data       (b_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [383:0] observed,
                       input logic [383:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQR  = 128'h0f0e0d0c0b0a09080706050403020100;
  localparam logic [127:0] DEAD  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
  localparam logic [127:0] PLAIN = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] MASK  = 128'h5a5a5a5ac3c3c3c3_0f0f0f0f96969696;
  localparam logic [127:0] W1    = 128'h11111111111111111111111111111111;
  localparam logic [127:0] W2    = 128'h22222222222222222222222222222222;
  localparam logic [127:0] W3    = 128'h33333333333333333333333333333333;
  localparam logic [127:0] ONES  = 128'hffffffffffffffffffffffffffffffff;
  localparam logic [127:0] S1    = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;
  localparam logic [127:0] S2    = 128'h00ff00ff00ff00ff00ff00ff00ff00ff;
  localparam logic [127:0] X3    = 128'hf00ff00ff00ff00ff00ff00ff00ff00f;

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    in_valid = 1'b0; in_bus = '0; in_interleaved = 1'b0;
    in_reverse = 1'b0; out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_bus = '0; b_in_interleaved = 1'b0;
    b_in_reverse = 1'b0; b_out_ready = 1'b1;

    #1;
    check("reset_in_ready", 384'(in_ready), 384'(1'b0));
    step(); step();
    check("reset_out_valid", 384'(out_valid), 384'(1'b0));
    check("reset_out_data", 384'(out_data), 384'(128'h0));
    rst = 1'b1;
    #1;
    check("post_reset_in_ready", 384'(in_ready), 384'(1'b1));

    // Interleave mapping
    in_valid = 1'b1; in_interleaved = 1'b1; in_reverse = 1'b0;
    in_bus = 256'h1;
    step();
    check("il1_valid", 384'(out_valid), 384'(1'b1));
    check("il1_shares", 384'(out_shares), 384'(256'h1));
    check("il1_data", 384'(out_data), 384'(128'h1));
    in_bus = 256'h2;
    step();
    check("il2_shares", 384'(out_shares), 384'({128'h1, 128'h0}));
    check("il2_data", 384'(out_data), 384'(128'h1));
    in_bus = 256'h3;
    step();
    check("il3_shares", 384'(out_shares), 384'({128'h1, 128'h1}));
    check("il3_data", 384'(out_data), 384'(128'h0));
    in_bus = 256'h1; in_reverse = 1'b1;
    step();
    check("il1_rev_data", 384'(out_data), 384'({8'h01, 120'h0}));

    // Recombine and reverse
    in_interleaved = 1'b0; in_reverse = 1'b1;
    in_bus = {128'h0, SEQ};
    step();
    check("rev_data", 384'(out_data), 384'(SEQR));
    check("rev_shares", 384'(out_shares), 384'({128'h0, SEQ}));
    in_reverse = 1'b0;
    step();
    check("norev_data", 384'(out_data), 384'(SEQ));

    // Masking cancellation
    in_bus = {DEAD, DEAD};
    step();
    check("cancel_data", 384'(out_data), 384'(128'h0));
    in_bus = {MASK, PLAIN ^ MASK};
    step();
    check("unmask_data", 384'(out_data), 384'(PLAIN));

    // Back-pressure: out_ready sequence 1,0,0,1,1 over three words
    in_valid = 1'b0;
    step();
    check("bp_idle_valid", 384'(out_valid), 384'(1'b0));
    in_valid = 1'b1; in_bus = {128'h0, W1}; out_ready = 1'b1;
    check("bp_ready0", 384'(in_ready), 384'(1'b1));
    step();
    check("bp_w1_data", 384'(out_data), 384'(W1));
    in_bus = {128'h0, W2}; out_ready = 1'b0;
    #1;
    check("bp_stall_ready", 384'(in_ready), 384'(1'b0));
    in_reverse = 1'b1; in_interleaved = 1'b1;
    step();
    check("bp_hold1_data", 384'(out_data), 384'(W1));
    check("bp_hold1_valid", 384'(out_valid), 384'(1'b1));
    check("bp_hold1_ready", 384'(in_ready), 384'(1'b0));
    step();
    check("bp_hold2_data", 384'(out_data), 384'(W1));
    check("bp_hold2_shares", 384'(out_shares), 384'({128'h0, W1}));
    in_reverse = 1'b0; in_interleaved = 1'b0; out_ready = 1'b1;
    #1;
    check("bp_release_ready", 384'(in_ready), 384'(1'b1));
    step();
    check("bp_w2_data", 384'(out_data), 384'(W2));
    check("bp_w2_valid", 384'(out_valid), 384'(1'b1));
    in_bus = {128'h0, W3};
    step();
    check("bp_w3_data", 384'(out_data), 384'(W3));
    in_valid = 1'b0;
    step();
    check("bp_drain_valid", 384'(out_valid), 384'(1'b0));
    check("bp_drain_data", 384'(out_data), 384'(W3));

    // Reset while a word is held
    in_valid = 1'b1; in_bus = {128'h0, W1}; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check("rst_held_valid", 384'(out_valid), 384'(1'b1));
    #2 rst = 1'b0;
    #1;
    check("rst_mid_valid", 384'(out_valid), 384'(1'b0));
    check("rst_mid_data", 384'(out_data), 384'(128'h0));
    check("rst_mid_shares", 384'(out_shares), 384'(256'h0));
    check("rst_mid_ready", 384'(in_ready), 384'(1'b0));
    step();
    rst = 1'b1;
    #1;
    check("rst_rel_ready", 384'(in_ready), 384'(1'b1));
    out_ready = 1'b1;

    // D=3 throughput: back-to-back words, one output per cycle
    b_in_valid = 1'b1; b_out_ready = 1'b1;
    b_in_bus = {S2, S1, ONES};
    step();
    check("d3_w0_valid", 384'(b_out_valid), 384'(1'b1));
    check("d3_w0_data", 384'(b_out_data), 384'(X3));
    b_in_bus = {PLAIN, MASK, DEAD};
    step();
    check("d3_w1_data", 384'(b_out_data), 384'(PLAIN ^ MASK ^ DEAD));
    check("d3_w1_ready", 384'(b_in_ready), 384'(1'b1));
    b_in_bus = {W3, W2, W1};
    step();
    check("d3_w2_data", 384'(b_out_data), 384'(128'h0));
    b_in_interleaved = 1'b1; b_in_bus = 384'h20;
    step();
    check("d3_il_data", 384'(b_out_data), 384'(128'h2));
    check("d3_il_shares", 384'(b_out_shares), 384'({128'h2, 128'h0, 128'h0}));
    b_in_valid = 1'b0;
    step();
    check("d3_drain_valid", 384'(b_out_valid), 384'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
